// File: rtl/chess_kbd_pkg.sv
// Shared scan codes, coordinate width, FSM encoding and slot record for
// keyboard move entry.
package chess_kbd_pkg;

  localparam int COORD_W = 3;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXTEND = 8'hE0;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_ESC    = 8'h76;
  localparam logic [7:0] SC_ENTER  = 8'h5A;

  // Index in each table is the decoded coordinate (A..H, 1..8 -> 0..7)
  localparam logic [7:0] SC_LETTER [8] = '{8'h1C, 8'h32, 8'h21, 8'h23,
                                           8'h24, 8'h2B, 8'h34, 8'h33};
  localparam logic [7:0] SC_DIGIT  [8] = '{8'h16, 8'h1E, 8'h26, 8'h25,
                                           8'h2E, 8'h36, 8'h3D, 8'h3E};

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_WRITE   = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;

  typedef struct packed {
    logic               letter_valid;
    logic               number_valid;
    logic [COORD_W-1:0] letter;
    logic [COORD_W-1:0] number;
  } slot_t;

  function automatic logic slot_full(input slot_t s);
    return s.letter_valid & s.number_valid;
  endfunction

endpackage

// File: rtl/scancode_decoder.sv
// Combinational decode of a PS/2 byte into a board letter or digit coordinate.
import chess_kbd_pkg::*;

module scancode_decoder (
  input  logic [7:0]         scancode,
  output logic               is_letter,
  output logic               is_number,
  output logic [COORD_W-1:0] code
);

  logic [7:0] letter_hit;
  logic [7:0] digit_hit;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_match
      assign letter_hit[gi] = (scancode == SC_LETTER[gi]);
      assign digit_hit[gi]  = (scancode == SC_DIGIT[gi]);
    end
  endgenerate

  // Letter and digit tables are disjoint, so at most one hit is set
  always_comb begin
    code = '0;
    for (int i = 0; i < 8; i++) begin
      if (letter_hit[i] || digit_hit[i]) code = COORD_W'(i);
    end
  end

  assign is_letter = |letter_hit;
  assign is_number = |digit_hit;

endmodule

// File: rtl/keyboard_move_entry.sv
// Collects a chess move typed on a PS/2 keyboard into NUM_SLOTS squares and,
// on Enter, writes the squares plus a move-ready flag to memory.
import chess_kbd_pkg::*;

module keyboard_move_entry #(
  parameter int          NUM_SLOTS = 2,
  parameter logic [11:0] BASE_ADDR = 12'd64,
  parameter int          SLOT_W    = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        ps2_key_data,
  input  logic              ps2_key_pressed,
  output logic              keyboard_we,
  output logic [11:0]       keyboard_write_address,
  output logic [31:0]       keyboard_write_data,
  output logic [SLOT_W-1:0] current_slot,
  output logic              entry_busy,
  output logic              entry_error
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [SLOT_W-1:0] ONE       = SLOT_W'(1);

  logic [1:0]        state_reg, state_next;
  slot_t             slot_reg  [NUM_SLOTS];
  slot_t             slot_next [NUM_SLOTS];
  logic [SLOT_W-1:0] cur_reg, cur_next;
  logic [SLOT_W-1:0] idx_reg, idx_next;
  logic              break_reg, break_next;
  logic              error_reg, error_next;

  logic               is_letter, is_number;
  logic [COORD_W-1:0] code;
  slot_t              cur_slot, edit_slot, wr_slot;
  logic               all_full;

  scancode_decoder u_decoder (
    .scancode  (ps2_key_data),
    .is_letter (is_letter),
    .is_number (is_number),
    .code      (code)
  );

  always_comb begin
    cur_slot = '0;
    wr_slot  = '0;
    all_full = 1'b1;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (SLOT_W'(i) == cur_reg) cur_slot = slot_reg[i];
      if (SLOT_W'(i) == idx_reg) wr_slot = slot_reg[i];
      all_full = all_full & slot_full(slot_reg[i]);
    end
  end

  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    idx_next   = idx_reg;
    break_next = break_reg;
    error_next = 1'b0;
    edit_slot  = cur_slot;
    for (int i = 0; i < NUM_SLOTS; i++) slot_next[i] = slot_reg[i];

    case (state_reg)
      ST_COLLECT: begin
        if (ps2_key_pressed) begin
          // A pending break swallows the release code whatever it is
          if (break_reg) begin
            break_next = 1'b0;
          end else if (ps2_key_data == SC_BREAK) begin
            break_next = 1'b1;
          end else if (is_letter || is_number) begin
            if (is_letter) begin
              edit_slot.letter       = code;
              edit_slot.letter_valid = 1'b1;
            end else begin
              edit_slot.number       = code;
              edit_slot.number_valid = 1'b1;
            end
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (SLOT_W'(i) == cur_reg) slot_next[i] = edit_slot;
            end
            if (!slot_full(cur_slot) && slot_full(edit_slot) && cur_reg != LAST_SLOT)
              cur_next = cur_reg + ONE;
          end else begin
            case (ps2_key_data)
              SC_LEFT:  if (cur_reg != '0) cur_next = cur_reg - ONE;
              SC_RIGHT: if (cur_reg != LAST_SLOT) cur_next = cur_reg + ONE;
              SC_BKSP: begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                  if (SLOT_W'(i) == cur_reg) begin
                    slot_next[i].letter_valid = 1'b0;
                    slot_next[i].number_valid = 1'b0;
                  end
                end
              end
              SC_ESC: begin
                for (int i = 0; i < NUM_SLOTS; i++) slot_next[i] = '0;
                cur_next = '0;
              end
              SC_ENTER: begin
                if (all_full) begin
                  state_next = ST_WRITE;
                  idx_next   = '0;
                end else begin
                  error_next = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end
      ST_WRITE: begin
        if (idx_reg == LAST_SLOT) state_next = ST_COMMIT;
        else idx_next = idx_reg + ONE;
      end
      ST_COMMIT: begin
        for (int i = 0; i < NUM_SLOTS; i++) slot_next[i] = '0;
        cur_next   = '0;
        state_next = ST_COLLECT;
      end
      default: state_next = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_COLLECT;
      cur_reg   <= '0;
      idx_reg   <= '0;
      break_reg <= 1'b0;
      error_reg <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) slot_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      cur_reg   <= cur_next;
      idx_reg   <= idx_next;
      break_reg <= break_next;
      error_reg <= error_next;
      for (int i = 0; i < NUM_SLOTS; i++) slot_reg[i] <= slot_next[i];
    end
  end

  always_comb begin
    keyboard_we            = 1'b0;
    keyboard_write_address = '0;
    keyboard_write_data    = '0;
    if (state_reg == ST_WRITE) begin
      keyboard_we            = 1'b1;
      keyboard_write_address = BASE_ADDR + 12'(idx_reg);
      keyboard_write_data    = {26'b0, wr_slot.number, wr_slot.letter};
    end else if (state_reg == ST_COMMIT) begin
      keyboard_we            = 1'b1;
      keyboard_write_address = BASE_ADDR + 12'(NUM_SLOTS);
      keyboard_write_data    = 32'd1;
    end
  end

  assign current_slot = cur_reg;
  assign entry_busy   = (state_reg != ST_COLLECT);
  assign entry_error  = error_reg;

endmodule

// File: tb/tb_keyboard_move_entry.sv
// Self-checking bench: vector table, hand-written corner sequences, and
// random keystrokes against a behavioural move-entry model.
module tb_keyboard_move_entry;

  localparam int NS   = 2;
  localparam int BASE = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  ps2_key_data = 8'h00;
  logic        ps2_key_pressed = 1'b0;
  logic        keyboard_we;
  logic [11:0] keyboard_write_address;
  logic [31:0] keyboard_write_data;
  logic [2:0]  current_slot;
  logic        entry_busy;
  logic        entry_error;

  keyboard_move_entry dut (
    .clock                  (clock),
    .reset                  (reset),
    .ps2_key_data           (ps2_key_data),
    .ps2_key_pressed        (ps2_key_pressed),
    .keyboard_we            (keyboard_we),
    .keyboard_write_address (keyboard_write_address),
    .keyboard_write_data    (keyboard_write_data),
    .current_slot           (current_slot),
    .entry_busy             (entry_busy),
    .entry_error            (entry_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] letter_sc [8] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33};
  logic [7:0] digit_sc  [8] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};
  bit m_lv [NS];
  bit m_nv [NS];
  int m_let [NS];
  int m_num [NS];
  int m_cur;
  bit m_brk;
  logic [31:0] exp_data [NS];

  function automatic int lookup(input logic [7:0] b, input bit digit);
    for (int i = 0; i < 8; i++) begin
      if (!digit && letter_sc[i] == b) return i;
      if (digit && digit_sc[i] == b) return i;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_lv[i] = 0; m_nv[i] = 0; m_let[i] = 0; m_num[i] = 0;
    end
    m_cur = 0;
  endtask

  task automatic model_step(input logic [7:0] b, output bit err, output bit commit);
    int  li, di;
    bit  was_full, full;
    err = 0;
    commit = 0;
    if (m_brk) begin m_brk = 0; return; end
    if (b == 8'hF0) begin m_brk = 1; return; end
    li = lookup(b, 0);
    di = lookup(b, 1);
    if (li >= 0 || di >= 0) begin
      was_full = m_lv[m_cur] && m_nv[m_cur];
      if (li >= 0) begin m_let[m_cur] = li; m_lv[m_cur] = 1; end
      else begin m_num[m_cur] = di; m_nv[m_cur] = 1; end
      if (!was_full && m_lv[m_cur] && m_nv[m_cur] && m_cur < NS - 1) m_cur++;
    end else begin
      case (b)
        8'h6B: if (m_cur > 0) m_cur--;
        8'h74: if (m_cur < NS - 1) m_cur++;
        8'h66: begin m_lv[m_cur] = 0; m_nv[m_cur] = 0; end
        8'h76: model_clear();
        8'h5A: begin
          full = 1;
          for (int i = 0; i < NS; i++) full &= m_lv[i] && m_nv[i];
          if (full) commit = 1; else err = 1;
        end
        default: ;
      endcase
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] b);
    @(negedge clock);
    ps2_key_data = b;
    ps2_key_pressed = 1'b1;
    @(negedge clock);
    ps2_key_pressed = 1'b0;
    ps2_key_data = 8'h00;
    $display("key 0x%02h -> slot %0d busy %0b err %0b", b, current_slot, entry_busy, entry_error);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    ps2_key_pressed = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    m_brk = 0;
  endtask

  // Called at the first negedge after Enter; checks the full write burst.
  task automatic run_commit(input string tag, input bit noise);
    for (int k = 0; k <= NS; k++) begin
      check({tag, "_we"}, 32'(keyboard_we), 1);
      check({tag, "_addr"}, 32'(keyboard_write_address), (k < NS) ? BASE + k : BASE + NS);
      check({tag, "_data"}, keyboard_write_data, (k < NS) ? exp_data[k] : 32'd1);
      check({tag, "_busy"}, 32'(entry_busy), 1);
      $display("write addr %0d data 0x%0h", keyboard_write_address, keyboard_write_data);
      if (noise) begin
        ps2_key_data = 8'($urandom);
        ps2_key_pressed = 1'b1;
      end
      @(negedge clock);
    end
    ps2_key_pressed = 1'b0;
    ps2_key_data = 8'h00;
    check({tag, "_we_after"}, 32'(keyboard_we), 0);
    check({tag, "_addr_after"}, 32'(keyboard_write_address), 0);
    check({tag, "_busy_after"}, 32'(entry_busy), 0);
    check({tag, "_slot_after"}, 32'(current_slot), 0);
  endtask

  task automatic step_model(input logic [7:0] b);
    bit e, c;
    model_step(b, e, c);
    send(b);
    check("rnd_err", 32'(entry_error), 32'(e));
    check("rnd_busy", 32'(entry_busy), 32'(c));
    if (c) begin
      for (int i = 0; i < NS; i++) exp_data[i] = 32'((m_num[i] << 3) | m_let[i]);
      run_commit("rnd", 1'b0);
      model_clear();
    end else begin
      check("rnd_slot", 32'(current_slot), 32'(m_cur));
      check("rnd_we_idle", 32'(keyboard_we), 0);
    end
  endtask

  typedef struct {
    logic [7:0] key;
    int         exp_slot;
    bit         exp_err;
  } vec_t;

  vec_t vecs [17];
  logic [7:0] pool [28];

  initial begin
    vecs[0]  = '{8'h1C, 0, 1'b0};  // A
    vecs[1]  = '{8'h5A, 0, 1'b1};  // Enter, incomplete
    vecs[2]  = '{8'h16, 1, 1'b0};  // 1 completes slot0
    vecs[3]  = '{8'h74, 1, 1'b0};
    vecs[4]  = '{8'h6B, 0, 1'b0};
    vecs[5]  = '{8'h6B, 0, 1'b0};
    vecs[6]  = '{8'h74, 1, 1'b0};
    vecs[7]  = '{8'h66, 1, 1'b0};
    vecs[8]  = '{8'h33, 1, 1'b0};  // H
    vecs[9]  = '{8'h3E, 1, 1'b0};  // 8 completes last slot, no advance
    vecs[10] = '{8'h6B, 0, 1'b0};
    vecs[11] = '{8'h66, 0, 1'b0};  // clear slot0
    vecs[12] = '{8'h5A, 0, 1'b1};
    vecs[13] = '{8'h1C, 0, 1'b0};
    vecs[14] = '{8'h16, 1, 1'b0};
    vecs[15] = '{8'h76, 0, 1'b0};  // escape
    vecs[16] = '{8'h5A, 0, 1'b1};

    for (int i = 0; i < 8; i++) begin
      pool[i] = letter_sc[i];
      pool[8 + i] = digit_sc[i];
    end
    pool[16] = 8'h6B; pool[17] = 8'h74; pool[18] = 8'h66; pool[19] = 8'h76;
    pool[20] = 8'h5A; pool[21] = 8'h5A; pool[22] = 8'h5A; pool[23] = 8'hF0;
    pool[24] = 8'hE0; pool[25] = 8'h00; pool[26] = 8'h4A; pool[27] = 8'h1C;

    // Reset state
    do_reset();
    check("rst_we", 32'(keyboard_we), 0);
    check("rst_addr", 32'(keyboard_write_address), 0);
    check("rst_data", keyboard_write_data, 0);
    check("rst_slot", 32'(current_slot), 0);
    check("rst_busy", 32'(entry_busy), 0);
    check("rst_err", 32'(entry_error), 0);

    // Vector table
    for (int i = 0; i < 17; i++) begin
      send(vecs[i].key);
      check("vec_slot", 32'(current_slot), 32'(vecs[i].exp_slot));
      check("vec_err", 32'(entry_error), 32'(vecs[i].exp_err));
      check("vec_we", 32'(keyboard_we), 0);
    end

    // E2E4
    do_reset();
    send(8'h24); send(8'h1E);
    check("e2e4_slot_mid", 32'(current_slot), 1);
    send(8'h24); send(8'h25);
    check("e2e4_slot_last", 32'(current_slot), 1);
    send(8'h5A);
    exp_data[0] = 32'h0C; exp_data[1] = 32'h1C;
    run_commit("e2e4", 1'b0);

    // Break prefix discards the release code
    do_reset();
    send(8'h24); send(8'hF0); send(8'h24); send(8'h1E);
    check("brk_slot", 32'(current_slot), 1);
    send(8'h23); send(8'h26);
    send(8'h5A);
    exp_data[0] = 32'h0C; exp_data[1] = 32'h13;
    run_commit("brk", 1'b0);

    // Rejected Enter keeps partial slot
    do_reset();
    send(8'h24); send(8'h5A);
    check("rej_err", 32'(entry_error), 1);
    check("rej_we", 32'(keyboard_we), 0);
    @(negedge clock);
    check("rej_err_pulse", 32'(entry_error), 0);
    check("rej_we2", 32'(keyboard_we), 0);
    send(8'h1E);
    check("rej_slot_kept", 32'(current_slot), 1);

    // Arrow saturation
    do_reset();
    send(8'h6B); check("sat_left", 32'(current_slot), 0);
    send(8'h74); check("sat_r1", 32'(current_slot), 1);
    send(8'h74); check("sat_r2", 32'(current_slot), 1);
    send(8'h74); check("sat_r3", 32'(current_slot), 1);

    // Reset during the write burst
    do_reset();
    send(8'h1C); send(8'h16); send(8'h1C); send(8'h16);
    send(8'h5A);
    check("abort_we0", 32'(keyboard_we), 1);
    check("abort_addr0", 32'(keyboard_write_address), BASE);
    @(negedge clock);
    check("abort_addr1", 32'(keyboard_write_address), BASE + 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_we_off", 32'(keyboard_we), 0);
    check("abort_busy", 32'(entry_busy), 0);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_write", 32'(keyboard_we), 0);
      @(negedge clock);
    end

    // Keys during busy are ignored
    do_reset();
    send(8'h2B); send(8'h3D); send(8'h21); send(8'h1E);
    send(8'h5A);
    exp_data[0] = 32'h35; exp_data[1] = 32'h0A;
    run_commit("busy_noise", 1'b1);
    send(8'h5A);
    check("busy_cleared_err", 32'(entry_error), 1);

    // Random keystrokes against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      step_model(pool[$urandom_range(0, 27)]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keyboard_move_entry.md
KEYBOARD_MOVE_ENTRY -- requirements
Module: keyboard_move_entry

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 2, giving the number of board squares per move (from, to, ...); legal range 2..8.
REQ-002 SHALL have parameter BASE_ADDR, default 12'd64, giving the first slot's write address.
REQ-003 SHALL have parameter SLOT_W, default 3, giving the width of the current_slot output.
REQ-004 SHALL have port clock  input  1  sole clock; all logic is on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port ps2_key_data  input  8  PS/2 scan-code byte.
REQ-007 SHALL have port ps2_key_pressed  input  1  one-cycle strobe meaning ps2_key_data is a new byte.
REQ-008 SHALL have port keyboard_we  output  1  write enable.
REQ-009 SHALL have port keyboard_write_address  output  12  write address.
REQ-010 SHALL have port keyboard_write_data  output  32  write data.
REQ-011 SHALL have port current_slot  output  SLOT_W  index of the slot being edited.
REQ-012 SHALL have port entry_busy  output  1  high while a commit sequence is running.
REQ-013 SHALL have port entry_error  output  1  one-cycle pulse when Enter is rejected.

Function
REQ-014 SHALL treat byte 0xF0 as a break prefix: set break_pending, and discard the next strobed byte (the release code) together with clearing the flag.
REQ-015 SHALL discard byte 0xE0 without state change; an arrow key is recognised by its second byte alone.
REQ-016 SHALL decode letters A..H (0x1C,0x32,0x21,0x23,0x24,0x2B,0x34,0x33) to codes 0..7, and write the code into the current slot's letter field, setting its letter-valid bit.
REQ-017 SHALL decode digits 1..8 (0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E) to codes 0..7, and write the code into the current slot's number field, setting its number-valid bit.
REQ-018 SHALL advance current_slot by one, in the same cycle, when a write completes both valid bits of the slot and the slot is not NUM_SLOTS-1.
REQ-019 SHALL decrement current_slot on 0x6B (left) and increment it on 0x74 (right), saturating at 0 and NUM_SLOTS-1; slot contents are unchanged.
REQ-020 SHALL clear both valid bits of the current slot on 0x66 (backspace), with current_slot unchanged.
REQ-021 SHALL clear all slots and set current_slot to 0 on 0x76 (escape).
REQ-022 SHALL ignore all other bytes.
REQ-023 SHALL use the FSM states COLLECT, WRITE and COMMIT.
REQ-024 On 0x5A (Enter) in COLLECT, when all slots are fully valid, SHALL move to WRITE on the next cycle; when any slot is not fully valid, SHALL pulse entry_error for one cycle and stay in COLLECT.
REQ-025 In WRITE SHALL assert keyboard_we for NUM_SLOTS consecutive cycles; on cycle i the address SHALL be BASE_ADDR+i and the data SHALL be {26'b0, number[2:0], letter[2:0]} of slot i.
REQ-026 After the last slot, SHALL enter COMMIT for one cycle: keyboard_we=1, address=BASE_ADDR+NUM_SLOTS, data=32'd1 (move-ready flag).
REQ-027 After COMMIT, SHALL return to COLLECT with all slots cleared and current_slot=0.
REQ-028 SHALL hold entry_busy high in WRITE and COMMIT, and SHALL ignore every strobed byte in those states, including break-prefix tracking.
REQ-029 Latency: Enter strobed in cycle N SHALL give keyboard_we high in cycles N+1..N+NUM_SLOTS+1.
REQ-030 When not writing, keyboard_we, keyboard_write_address and keyboard_write_data SHALL all be 0.
REQ-031 Decoded state SHALL be visible one cycle after the strobe.

Reset
REQ-032 Reset SHALL put the FSM in COLLECT, clear all slots and break_pending, and set current_slot=0 and entry_busy=0, entry_error=0, keyboard_we=0, address=0, data=0.
REQ-033 Reset during WRITE or COMMIT SHALL abort the sequence, with keyboard_we low from the next cycle; reset has priority over a simultaneous strobe.

Structure
REQ-034 Scan-code constants, the 3-bit coordinate width and the FSM state encoding SHALL live in the shared package chess_kbd_pkg.
REQ-035 Decoding SHALL be a combinational sub-module, scancode_decoder, with byte input and outputs is_letter, is_number, code[2:0].

Verification
REQ-036 Strobe 24,1E,24,25,5A (E2E4) -> writes (64,0x0C), (65,0x1C), (66,0x1) in the three cycles after Enter; then current_slot=0.
REQ-037 Strobe 24,F0,24,1E -> the second 24 is discarded; slot0 is letter 4, number 1; current_slot=1.
REQ-038 Strobe 24,5A -> entry_error pulses for one cycle; keyboard_we stays 0; slot0 letter stays valid.
REQ-039 Strobe 6B at slot 0, then 74 three times with NUM_SLOTS=2 -> current_slot goes 0,1,1 (saturation).
REQ-040 Fill both slots, Enter, and assert reset on the 2nd write cycle -> keyboard_we=0 from the next cycle; no write to address 66.
REQ-041 Strobe keys during entry_busy -> slot contents are unchanged after COMMIT.
